multicycle_control_fsm: RTL and testbench

Control unit for the multi-cycle, non-pipelined processor. It sequences each instruction through fetch, decode, execute, memory and writeback. In every cycle it drives the datapath selects and enables (PC, IR, register file, ALU, data memory) from its current state and from the instruction held in the IR. It also counts retired instructions for bring-up and debug.

---
 rtl/multicycle_control_fsm.sv | 147 ++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Control unit for the multi-cycle processor: steps each instruction through
// IF/DEC/EXEC/MEM/WB and drives the datapath controls from state and IR.
module multicycle_control_fsm #(
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [31:0]      Instr,
   input  logic             Zero,
   input  logic             MEM_Ready,
   output logic             PC_sel,
   output logic             PC_LdEn,
   output logic             IR_LdEn,
   output logic             RF_WrData_sel,
   output logic             RF_B_sel,
   output logic             RF_WrEn,
   output logic             ALU_Bin_sel,
   output logic [3:0]       ALU_func,
   output logic             MEM_WrEn,
   output logic             MEM_RdEn,
   output logic [2:0]       State,
   output logic [CNT_W-1:0] Retired
);

   typedef enum logic [2:0] {
      ST_IF   = 3'b000,
      ST_DEC  = 3'b001,
      ST_EXEC = 3'b010,
      ST_MEM  = 3'b011,
      ST_WB   = 3'b100
   } state_t;

   state_t state, next_state;

   logic [5:0] opcode;
   logic       is_rtype, is_addi, is_andi, is_ori;
   logic       is_beq, is_bne, is_b, is_lw, is_sw, is_nop;
   logic       is_flow, is_mem, reads_rd;
   logic [3:0] exec_func;
   logic       exec_bin;
   logic       unused_instr;

   assign opcode   = Instr[31:26];
   assign is_rtype = (opcode == 6'b100000);
   assign is_addi  = (opcode == 6'b110000);
   assign is_andi  = (opcode == 6'b110010);
   assign is_ori   = (opcode == 6'b110011);
   assign is_beq   = (opcode == 6'b000000);
   assign is_bne   = (opcode == 6'b000001);
   assign is_b     = (opcode == 6'b111111);
   assign is_lw    = (opcode == 6'b001111);
   assign is_sw    = (opcode == 6'b011111);
   assign is_nop   = ~(is_rtype | is_addi | is_andi | is_ori | is_beq |
                       is_bne | is_b | is_lw | is_sw);
   assign is_flow  = is_beq | is_bne | is_b | is_nop;
   assign is_mem   = is_lw | is_sw;
   assign reads_rd = is_sw | is_beq | is_bne;
   assign exec_bin = is_addi | is_andi | is_ori | is_lw | is_sw;
   assign unused_instr = ^Instr[25:4];

   always_comb begin
      exec_func = 4'b0000;
      if (is_rtype)               exec_func = Instr[3:0];
      else if (is_andi)           exec_func = 4'b0010;
      else if (is_ori)            exec_func = 4'b0011;
      else if (is_beq || is_bne)  exec_func = 4'b0001;
   end

   // Controls are a pure decode of state and IR; Reset masks every output so
   // no strobe (in particular a pending memory write) survives into reset.
   always_comb begin
      next_state    = state;
      PC_sel        = 1'b0;
      PC_LdEn       = 1'b0;
      IR_LdEn       = 1'b0;
      RF_WrData_sel = 1'b0;
      RF_B_sel      = 1'b0;
      RF_WrEn       = 1'b0;
      ALU_Bin_sel   = 1'b0;
      ALU_func      = 4'b0000;
      MEM_WrEn      = 1'b0;
      MEM_RdEn      = 1'b0;
      if (!Reset) begin
         case (state)
            ST_IF: begin
               IR_LdEn    = 1'b1;
               next_state = ST_DEC;
            end
            ST_DEC: begin
               RF_B_sel   = reads_rd;
               next_state = ST_EXEC;
            end
            ST_EXEC: begin
               RF_B_sel    = reads_rd;
               ALU_func    = exec_func;
               ALU_Bin_sel = exec_bin;
               if (is_flow) begin
                  PC_LdEn    = 1'b1;
                  PC_sel     = is_b | (is_beq & Zero) | (is_bne & ~Zero);
                  next_state = ST_IF;
               end else if (is_mem) begin
                  next_state = ST_MEM;
               end else begin
                  next_state = ST_WB;
               end
            end
            ST_MEM: begin
               ALU_func    = 4'b0000;
               ALU_Bin_sel = 1'b1;
               MEM_RdEn    = is_lw;
               MEM_WrEn    = is_sw;
               RF_B_sel    = is_sw;
               if (MEM_Ready) begin
                  if (is_lw) begin
                     next_state = ST_WB;
                  end else begin
                     PC_LdEn    = 1'b1;
                     next_state = ST_IF;
                  end
               end
            end
            ST_WB: begin
               RF_WrEn       = 1'b1;
               PC_LdEn       = 1'b1;
               RF_WrData_sel = is_lw;
               ALU_func      = exec_func;
               ALU_Bin_sel   = exec_bin;
               next_state    = ST_IF;
            end
            default: next_state = ST_IF;
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state   <= ST_IF;
         Retired <= '0;
      end else begin
         state <= next_state;
         if (PC_LdEn) Retired <= Retired + CNT_W'(1);
      end
   end

   assign State = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomised bench for multicycle_control_fsm: builds each instruction's
// expected state walk from its latency rules and checks every cycle's controls.
module tb_multicycle_control_fsm;

   localparam int CNT_W = 4;

   localparam int C_RTYPE = 0, C_ADDI = 1, C_ANDI = 2, C_ORI = 3, C_BEQ = 4;
   localparam int C_BNE = 5, C_B = 6, C_LW = 7, C_SW = 8, C_NOP = 9;

   logic             Clk = 1'b0;
   logic             Reset;
   logic [31:0]      Instr;
   logic             Zero;
   logic             MEM_Ready;
   logic             PC_sel, PC_LdEn, IR_LdEn, RF_WrData_sel, RF_B_sel, RF_WrEn;
   logic             ALU_Bin_sel, MEM_WrEn, MEM_RdEn;
   logic [3:0]       ALU_func;
   logic [2:0]       State;
   logic [CNT_W-1:0] Retired;
   logic [15:0]      dutVec;

   int testsRun  = 0;
   int failCount = 0;
   int retiredModel = 0;

   multicycle_control_fsm #(.CNT_W(CNT_W)) dut (
      .Clk(Clk), .Reset(Reset), .Instr(Instr), .Zero(Zero), .MEM_Ready(MEM_Ready),
      .PC_sel(PC_sel), .PC_LdEn(PC_LdEn), .IR_LdEn(IR_LdEn),
      .RF_WrData_sel(RF_WrData_sel), .RF_B_sel(RF_B_sel), .RF_WrEn(RF_WrEn),
      .ALU_Bin_sel(ALU_Bin_sel), .ALU_func(ALU_func), .MEM_WrEn(MEM_WrEn),
      .MEM_RdEn(MEM_RdEn), .State(State), .Retired(Retired)
   );

   always #5 Clk = ~Clk;

   assign dutVec = {PC_sel, PC_LdEn, IR_LdEn, RF_WrData_sel, RF_B_sel, RF_WrEn,
                    ALU_Bin_sel, ALU_func, MEM_WrEn, MEM_RdEn, State};

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   function automatic logic [5:0] opcodeOf(input int cls);
      case (cls)
         C_RTYPE: return 6'b100000;
         C_ADDI:  return 6'b110000;
         C_ANDI:  return 6'b110010;
         C_ORI:   return 6'b110011;
         C_BEQ:   return 6'b000000;
         C_BNE:   return 6'b000001;
         C_B:     return 6'b111111;
         C_LW:    return 6'b001111;
         C_SW:    return 6'b011111;
         default: return 6'b000010;
      endcase
   endfunction

   function automatic bit isListed(input logic [5:0] op);
      for (int c = C_RTYPE; c < C_NOP; c++)
         if (opcodeOf(c) == op) return 1'b1;
      return 1'b0;
   endfunction

   // Expected control word for one cycle, straight from the per-state rules.
   function automatic logic [15:0] expVec(input int cls, input int st, input logic z,
                                          input logic rdy, input logic [3:0] fn);
      logic pcsel, pcld, ir, wds, brd, we, bin, wr, rd;
      logic [3:0] func;
      bit flow;
      flow  = (cls == C_BEQ) || (cls == C_BNE) || (cls == C_B) || (cls == C_NOP);
      ir    = (st == 0);
      brd   = (st != 0) && ((cls == C_SW) || (cls == C_BEQ) || (cls == C_BNE));
      func  = 4'b0000;
      bin   = 1'b0;
      pcsel = 1'b0;
      pcld  = 1'b0;
      if (st == 2 || st == 4) begin
         case (cls)
            C_RTYPE:      func = fn;
            C_ANDI:       func = 4'b0010;
            C_ORI:        func = 4'b0011;
            C_BEQ, C_BNE: func = 4'b0001;
            default:      func = 4'b0000;
         endcase
         bin = (cls == C_ADDI) || (cls == C_ANDI) || (cls == C_ORI) ||
               (cls == C_LW) || (cls == C_SW);
      end
      if (st == 3) bin = 1'b1;
      if (st == 2 && flow) begin
         pcld  = 1'b1;
         pcsel = (cls == C_B) || ((cls == C_BEQ) && z) || ((cls == C_BNE) && !z);
      end
      if (st == 3 && cls == C_SW && rdy) pcld = 1'b1;
      if (st == 4) pcld = 1'b1;
      rd  = (st == 3) && (cls == C_LW);
      wr  = (st == 3) && (cls == C_SW);
      we  = (st == 4);
      wds = (st == 4) && (cls == C_LW);
      return {pcsel, pcld, ir, wds, brd, we, bin, func, wr, rd, 3'(st)};
   endfunction

   // Runs one instruction; resetAt >= 0 pulses Reset during that cycle index.
   task automatic applyStimulus(input int cls, input int waits, input logic z,
                                input int func, input int resetAt);
      logic [31:0] r, instr;
      logic [5:0]  op;
      logic [15:0] exp;
      logic        rdy;
      int          sts[$];
      int          memIdx;
      bit          flow;
      op = opcodeOf(cls);
      if (cls == C_NOP) begin
         op = 6'($urandom_range(0, 63));
         while (isListed(op)) op = 6'($urandom_range(0, 63));
      end
      r     = $urandom();
      instr = {op, r[25:0]};
      if (func >= 0) instr[3:0] = 4'(func);
      flow = (cls == C_BEQ) || (cls == C_BNE) || (cls == C_B) || (cls == C_NOP);
      sts = {0, 1, 2};
      if (cls == C_LW || cls == C_SW)
         for (int i = 0; i <= waits; i++) sts.push_back(3);
      if (cls == C_LW || (!flow && cls != C_SW)) sts.push_back(4);
      memIdx = 0;
      for (int k = 0; k < sts.size(); k++) begin
         Instr = instr;
         Zero  = z;
         if (sts[k] == 3) begin
            rdy = (memIdx == waits);
            memIdx++;
         end else begin
            rdy = 1'($urandom_range(0, 1));
         end
         MEM_Ready = rdy;
         #2;
         exp = expVec(cls, sts[k], z, rdy, instr[3:0]);
         checkOutput("controls", 32'(dutVec), 32'(exp));
         checkOutput("retired", 32'(Retired), 32'(retiredModel % (1 << CNT_W)));
         if (k == resetAt) begin
            Reset = 1'b1;
            #1;
            checkOutput("reset_controls", 32'(dutVec), 32'd0);
            checkOutput("reset_retired", 32'(Retired), 32'd0);
            retiredModel = 0;
            @(posedge Clk);
            #1;
            Reset = 1'b0;
            return;
         end
         @(posedge Clk);
         #1;
         if (exp[14]) retiredModel++;
      end
   endtask

   initial begin
      Reset     = 1'b1;
      Instr     = '0;
      Zero      = 1'b0;
      MEM_Ready = 1'b0;
      repeat (2) begin
         @(negedge Clk);
         checkOutput("reset_hold_controls", 32'(dutVec), 32'd0);
         checkOutput("reset_hold_retired", 32'(Retired), 32'd0);
      end
      Reset = 1'b0;

      applyStimulus(C_RTYPE, 0, 1'b0, 1, -1);
      applyStimulus(C_LW, 2, 1'b0, -1, -1);
      applyStimulus(C_BEQ, 0, 1'b1, -1, -1);
      applyStimulus(C_BNE, 0, 1'b1, -1, -1);
      for (int n = 0; n < 16; n++) applyStimulus(C_NOP, 0, 1'($urandom_range(0, 1)), -1, -1);

      for (int n = 0; n < 200; n++)
         applyStimulus($urandom_range(0, 9), $urandom_range(0, 3),
                       1'($urandom_range(0, 1)), -1, -1);

      applyStimulus(C_SW, 3, 1'b0, -1, 4);
      applyStimulus(C_ADDI, 0, 1'b0, -1, -1);
      #2;
      checkOutput("final_retired", 32'(Retired), 32'(retiredModel % (1 << CNT_W)));

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
